truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//   Parametrised SOP/POS equivalence checker for N-input Boolean functions.
//   Holds a minterm mask (SOP form) and a maxterm mask (POS form), both loaded at run time.
//   On start it sweeps all 2**N input rows, one row per accepted cycle, and streams x, f_sop, f_pos and match.
//   Accumulates mismatch statistics. Replaces the per-function hand-written SOP/POS modules and their testbenches.
// PARAMETERS
//   N   4       number of function inputs (1..8); input row x is N bits, x[N-1] = MSB (leftmost variable)
//   R   2**N    rows in the table (derived, localparam; not overridable)
// PORTS
//   clk             in   1    rising-edge clock
//   reset           in   1    synchronous, active-high reset
//   cfg_we          in   1    write strobe for a mask register
//   cfg_sel         in   1    0 = SOP minterm mask, 1 = POS maxterm mask
//   cfg_data        in   R    mask value; bit i corresponds to row i
//   start           in   1    pulse: begin sweep (honoured in IDLE only)
//   busy            out  1    high in SWEEP and DONE
//   done            out  1    one-cycle pulse when sweep completes
//   out_valid       out  1    row output valid
//   out_ready       in   1    consumer accepts row when out_valid & out_ready
//   out_x           out  N    current row index
//   out_sop         out  1    sop_mask[out_x]
//   out_pos         out  1    ~pos_mask[out_x] (maxterm present -> 0)
//   out_match       out  1    out_sop == out_pos
//   mismatch_count  out  N+1  mismatching rows in the last sweep (0..R)
//   first_mismatch  out  N    lowest mismatching row index; 0 if none
//   any_mismatch    out  1    mismatch_count != 0
// BEHAVIOUR
//   Reset state and outputs:
//   - reset: state = IDLE; sop_mask = 0; pos_mask = 0; row index = 0.
//   - All outputs 0 during reset, including mismatch_count, first_mismatch and any_mismatch.
//   - reset mid-sweep aborts immediately: no done pulse, statistics cleared.
//   Mask writes:
//   - Committed at the clock edge when cfg_we = 1 in IDLE.
//   - Ignored while busy (masks are stable during a sweep).
//   - cfg_we and start in the same IDLE cycle: the write commits, and the sweep uses the new mask from row 0.
//   FSM:
//   - IDLE -> SWEEP on start: row index = 0; mismatch_count, first_mismatch and any_mismatch cleared.
//   - SWEEP: out_valid = 1 and out_* are combinational from the index and masks.
//   - A row is accepted when out_ready = 1; acceptance updates the statistics at that edge.
//     - mismatch_count increments on each mismatching row.
//     - first_mismatch is captured only on the first mismatch.
//   - Accepted row R-1 -> DONE; otherwise the index increments.
//   - out_ready = 0 holds the row and all out_* stable (no skipped or duplicated rows).
//   - DONE: done = 1, out_valid = 0, busy = 1 for exactly one cycle -> IDLE.
//   - start in SWEEP or DONE is ignored.
//   Timing:
//   - Latency with out_ready tied high: start sampled at edge 0; rows 0..R-1 presented in cycles 1..R; done in cycle R+1.
//   - Total sweep time is R+1 cycles plus stall cycles.
//   Statistics:
//   - Hold their last values in IDLE until the next start or reset.
//   - Are stable and final in the done cycle.
//   Width rules:
//   - mismatch_count saturates naturally at R, which fits in N+1 bits.
//   - The index counter is N bits; it never wraps inside a sweep.
//   Outputs in IDLE: out_valid = 0; out_x = 0; out_sop, out_pos and out_match follow row 0.
// TESTING  (N = 3 instance unless stated)
//   Test 1, equal forms:
//   - Stimulus: reset 2 cycles; write SOP = 8'b1011_1001 (minterms 0,3,4,5,7); write POS = 8'b0100_0110 (maxterms 1,2,6); start, out_ready = 1.
//   - Required: 8 rows, all out_match = 1; done in cycle 9; mismatch_count = 0; any_mismatch = 0.
//   Test 2, single mismatch:
//   - Stimulus: rewrite POS = 8'b0100_0010, then start.
//   - Required: row 2 shows sop = 0, pos = 1, match = 0; mismatch_count = 1; first_mismatch = 3'd2; any_mismatch = 1.
//   Test 3, backpressure:
//   - Stimulus: out_ready toggles 1,0,0,1,... during the sweep.
//   - Required: rows 0..7 each accepted exactly once, in order; out_x held while stalled; statistics identical to the no-stall run.
//   Test 4, ignored controls:
//   - Stimulus: cfg_we with new data and a second start pulse, both mid-sweep.
//   - Required: masks unchanged; the sweep continues undisturbed; exactly one done.
//   Test 5, reset mid-sweep:
//   - Stimulus: assert reset at row 4.
//   - Required: next cycle busy = 0, out_valid = 0, mismatch_count = 0, masks = 0; no done pulse.
//   Test 6, default N = 4, all-zero masks:
//   - Stimulus: start with both masks 0 (sop = 0, pos = 1 on every row).
//   - Required: mismatch_count = 5'd16; first_mismatch = 0; done 17 cycles after start.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 2**N rows of a run-time SOP minterm mask and POS maxterm mask, streams per-row values and accumulates mismatch statistics
//   clk, reset           rising-edge clock, synchronous active-high reset
//   cfg_we/sel/data      mask write in IDLE (sel 0 = SOP minterms, 1 = POS maxterms), bit i = row i
//   start                begin a sweep (IDLE only)
//   busy, done           busy in SWEEP/DONE; done pulses for the single DONE cycle
//   out_valid/ready      row handshake; out_x/out_sop/out_pos/out_match describe the current row
//   mismatch_count       mismatching rows of the last sweep
//   first_mismatch       lowest mismatching row, 0 if none
//   any_mismatch         mismatch_count != 0
module truth_table_sweeper #(
    parameter int N = 4,
    localparam int R = 1 << N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_we,
    input  logic         cfg_sel,
    input  logic [R-1:0] cfg_data,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_x,
    output logic         out_sop,
    output logic         out_pos,
    output logic         out_match,
    output logic [N:0]   mismatch_count,
    output logic [N-1:0] first_mismatch,
    output logic         any_mismatch
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    localparam logic [N-1:0] LAST = N'(R - 1);
    state_t state, state_n;
    logic [R-1:0] sop_mask, pos_mask;
    logic [N-1:0] idx, first;
    logic [N:0] cnt;
    logic sop_bit, pos_bit, accept;
    always_comb begin
        sop_bit = sop_mask[idx];
        pos_bit = !pos_mask[idx];
        accept = state == SWEEP && out_ready;
        state_n = (state == IDLE && start) ? SWEEP :
                  (accept && idx == LAST) ? DONE :
                  (state == DONE) ? IDLE : state;
        // every output is forced low while reset is asserted, before the registers clear
        busy = !reset && state != IDLE;
        done = !reset && state == DONE;
        out_valid = !reset && state == SWEEP;
        out_x = reset ? '0 : idx;
        out_sop = !reset && sop_bit;
        out_pos = !reset && pos_bit;
        out_match = !reset && sop_bit == pos_bit;
        mismatch_count = reset ? '0 : cnt;
        first_mismatch = reset ? '0 : first;
        any_mismatch = !reset && cnt != '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sop_mask <= '0;
            pos_mask <= '0;
            idx <= '0;
            cnt <= '0;
            first <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && cfg_we && !cfg_sel) sop_mask <= cfg_data;
            if (state == IDLE && cfg_we && cfg_sel) pos_mask <= cfg_data;
            if (state == IDLE && start) begin
                idx <= '0;
                cnt <= '0;
                first <= '0;
            end else if (accept) begin
                // the increment past the last row wraps to 0, leaving IDLE presenting row 0
                idx <= idx + 1'b1;
                if (sop_bit != pos_bit) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) first <= idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table-driven, hand-written and randomized checks of truth_table_sweeper (N = 3 and N = 4)
module tb_truth_table_sweeper;
    typedef struct {
        logic [7:0] s;
        logic [7:0] p;
        int mode;
        int cnt;
        int first;
    } vec_t;
    logic clk = 0;
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0;
    logic reset3, cfg_we3, cfg_sel3, start3, out_ready3;
    logic [7:0] cfg_data3;
    logic busy3, done3, out_valid3, out_sop3, out_pos3, out_match3, any3;
    logic [2:0] out_x3, first3;
    logic [3:0] cnt3;
    logic reset4, cfg_we4, cfg_sel4, start4, out_ready4;
    logic [15:0] cfg_data4;
    logic busy4, done4, out_valid4, out_sop4, out_pos4, out_match4, any4;
    logic [3:0] out_x4, first4;
    logic [4:0] cnt4;
    truth_table_sweeper #(.N(3)) u3 (
        .clk(clk), .reset(reset3), .cfg_we(cfg_we3), .cfg_sel(cfg_sel3), .cfg_data(cfg_data3),
        .start(start3), .busy(busy3), .done(done3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_x(out_x3), .out_sop(out_sop3), .out_pos(out_pos3), .out_match(out_match3),
        .mismatch_count(cnt3), .first_mismatch(first3), .any_mismatch(any3)
    );
    truth_table_sweeper #(.N(4)) u4 (
        .clk(clk), .reset(reset4), .cfg_we(cfg_we4), .cfg_sel(cfg_sel4), .cfg_data(cfg_data4),
        .start(start4), .busy(busy4), .done(done4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_x(out_x4), .out_sop(out_sop4), .out_pos(out_pos4), .out_match(out_match4),
        .mismatch_count(cnt4), .first_mismatch(first4), .any_mismatch(any4)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    // reference: row i is a mismatch when the minterm bit differs from the complemented maxterm bit
    function automatic void model(input logic [7:0] s, input logic [7:0] p, output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            if (s[i] != !p[i]) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endfunction
    task automatic write3(input logic sel, input logic [7:0] d);
        cfg_we3 = 1;
        cfg_sel3 = sel;
        cfg_data3 = d;
        @(posedge clk); #1;
        cfg_we3 = 0;
    endtask
    task automatic sweep3(input string nm, input logic [7:0] s, input logic [7:0] p, input int mode,
                          input bit disturb, input int ecnt, input int efirst);
        int row, cyc, stalls;
        bit fin;
        write3(0, s);
        write3(1, p);
        start3 = 1;
        @(posedge clk); #1;
        start3 = 0;
        row = 0;
        cyc = 1;
        stalls = 0;
        fin = 0;
        while (!fin && cyc <= 200) begin
            out_ready3 = mode == 0 ? 1'b1 : mode == 1 ? ((cyc - 1) % 3 == 0) : 1'($urandom);
            if (disturb) begin
                cfg_we3 = cyc == 3 || cyc == 4;
                cfg_sel3 = cyc == 4;
                cfg_data3 = cyc == 3 ? 8'hFF : 8'h00;
                start3 = cyc == 3 || cyc == 5;
            end
            if (row < 8) begin
                chk({nm, ".valid"}, 32'(out_valid3), 1);
                chk({nm, ".busy"}, 32'(busy3), 1);
                chk({nm, ".early_done"}, 32'(done3), 0);
                chk({nm, ".x"}, 32'(out_x3), row);
                chk({nm, ".sop"}, 32'(out_sop3), 32'(s[row]));
                chk({nm, ".pos"}, 32'(out_pos3), 32'(!p[row]));
                chk({nm, ".match"}, 32'(out_match3), 32'(s[row] == !p[row]));
                if (out_ready3) row++;
                else stalls++;
            end else begin
                fin = 1;
                chk({nm, ".done"}, 32'(done3), 1);
                chk({nm, ".done_valid"}, 32'(out_valid3), 0);
                chk({nm, ".done_busy"}, 32'(busy3), 1);
                chk({nm, ".done_cycle"}, cyc, 9 + stalls);
                chk({nm, ".count"}, 32'(cnt3), ecnt);
                chk({nm, ".first"}, 32'(first3), efirst);
                chk({nm, ".any"}, 32'(any3), 32'(ecnt != 0));
            end
            @(posedge clk); #1;
            cyc++;
        end
        cfg_we3 = 0;
        start3 = 0;
        if (!fin) chk({nm, ".timeout"}, 0, 1);
        chk({nm, ".idle_busy"}, 32'(busy3), 0);
        chk({nm, ".idle_done"}, 32'(done3), 0);
        chk({nm, ".idle_valid"}, 32'(out_valid3), 0);
        chk({nm, ".idle_x"}, 32'(out_x3), 0);
        chk({nm, ".idle_count"}, 32'(cnt3), ecnt);
        chk({nm, ".idle_first"}, 32'(first3), efirst);
    endtask
    initial begin
        vec_t tbl[6];
        int ec, ef, k;
        bit saw;
        logic [7:0] s, p;
        tbl[0] = '{8'b1011_1001, 8'b0100_0110, 0, 0, 0};
        tbl[1] = '{8'b1011_1001, 8'b0100_0010, 0, 1, 2};
        tbl[2] = '{8'b1011_1001, 8'b0100_0010, 1, 1, 2};
        tbl[3] = '{8'h00, 8'h00, 0, 8, 0};
        tbl[4] = '{8'h01, 8'h80, 1, 6, 1};
        tbl[5] = '{8'h7F, 8'h00, 2, 1, 7};
        {reset3, cfg_we3, cfg_sel3, start3, out_ready3, cfg_data3} = {5'b10001, 8'h00};
        {reset4, cfg_we4, cfg_sel4, start4, out_ready4, cfg_data4} = {5'b10001, 16'h0000};
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy3), 0);
        chk("rst.done", 32'(done3), 0);
        chk("rst.valid", 32'(out_valid3), 0);
        chk("rst.x", 32'(out_x3), 0);
        chk("rst.pos", 32'(out_pos3), 0);
        chk("rst.match", 32'(out_match3), 0);
        chk("rst.count", 32'(cnt3), 0);
        chk("rst.any", 32'(any3), 0);
        chk("rst4.pos", 32'(out_pos4), 0);
        reset3 = 0;
        reset4 = 0;
        #1;
        chk("idle.pos_row0", 32'(out_pos3), 1);
        chk("idle.sop_row0", 32'(out_sop3), 0);
        for (int i = 0; i < 6; i++) sweep3($sformatf("tbl%0d", i), tbl[i].s, tbl[i].p, tbl[i].mode, 0, tbl[i].cnt, tbl[i].first);
        sweep3("ignored", 8'b1011_1001, 8'b0100_0110, 0, 1, 0, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("ignored.no_second_done", 32'(done3), 0);
        end
        for (int i = 0; i < 8; i++) begin
            s = 8'($urandom);
            p = 8'($urandom);
            model(s, p, ec, ef);
            sweep3($sformatf("rnd%0d", i), s, p, int'($urandom_range(0, 2)), 0, ec, ef);
        end
        write3(0, 8'h00);
        write3(1, 8'h00);
        out_ready3 = 1;
        start3 = 1;
        @(posedge clk); #1;
        start3 = 0;
        k = 0;
        while (out_x3 != 3'd4 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_mid.reach_row4", 32'(out_x3), 4);
        chk("rst_mid.count_before", 32'(cnt3), 4);
        reset3 = 1;
        @(posedge clk); #1;
        chk("rst_mid.held_busy", 32'(busy3), 0);
        chk("rst_mid.held_count", 32'(cnt3), 0);
        reset3 = 0;
        #1;
        chk("rst_mid.busy", 32'(busy3), 0);
        chk("rst_mid.valid", 32'(out_valid3), 0);
        chk("rst_mid.count", 32'(cnt3), 0);
        chk("rst_mid.any", 32'(any3), 0);
        chk("rst_mid.sop_mask", 32'(out_sop3), 0);
        chk("rst_mid.pos_mask", 32'(out_pos3), 1);
        saw = 0;
        repeat (10) begin
            @(posedge clk); #1;
            saw |= done3;
        end
        chk("rst_mid.no_done", 32'(saw), 0);
        start4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        k = 1;
        while (!done4 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("n4.done", 32'(done4), 1);
        chk("n4.done_cycle", k, 17);
        chk("n4.count", 32'(cnt4), 16);
        chk("n4.first", 32'(first4), 0);
        chk("n4.any", 32'(any4), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
